// File: rtl/nx_grid_sequencer.sv
// Mesh-level evaluation sequencer: waits for a quiescent node grid, fires one
// trigger per simulated cycle and counts triggers until a target or a stop request.
module nx_grid_sequencer #(
    parameter int unsigned NODES   = 16,
    parameter int unsigned COUNT_W = 32,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [COUNT_W-1:0] i_cycles,
    input  logic [NODES-1:0]   i_node_idle,
    output logic               o_trigger,
    output logic               o_active,
    output logic               o_done,
    output logic [COUNT_W-1:0] o_cycle_count
);

    localparam int unsigned SET_W  = $clog2(SETTLE + 1);
    localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    logic [1:0]         state, state_n;
    logic [SET_W-1:0]   settle_cnt, settle_cnt_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
    logic               stop_pend, stop_pend_n;
    logic [COUNT_W-1:0] target, target_n;
    logic [COUNT_W-1:0] count_n;
    logic               trigger_n, active_n, done_n;
    logic               all_idle;

    assign all_idle = &i_node_idle;

    // Next-state and next-output decode.
    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        hold_cnt_n   = hold_cnt;
        stop_pend_n  = stop_pend;
        target_n     = target;
        count_n      = o_cycle_count;
        trigger_n    = 1'b0;
        done_n       = 1'b0;
        active_n     = o_active;

        case (state)
            ST_STOPPED: begin
                if (i_start && !i_stop) begin
                    target_n     = i_cycles;
                    count_n      = '0;
                    stop_pend_n  = 1'b0;
                    active_n     = 1'b1;
                    settle_cnt_n = '0;
                    state_n      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (i_stop) stop_pend_n = 1'b1;
                if (!all_idle) begin
                    settle_cnt_n = '0;
                end else if (settle_cnt == SET_W'(SETTLE - 1)) begin
                    settle_cnt_n = '0;
                    if (stop_pend || (target != '0 && o_cycle_count == target)) begin
                        done_n      = 1'b1;
                        active_n    = 1'b0;
                        stop_pend_n = 1'b0;
                        state_n     = ST_STOPPED;
                    end else begin
                        trigger_n  = 1'b1;
                        hold_cnt_n = '0;
                        state_n    = ST_HOLDOFF;
                        // Saturate rather than wrap so long runs stay monotonic.
                        if (o_cycle_count != '1) count_n = o_cycle_count + COUNT_W'(1);
                    end
                end else begin
                    settle_cnt_n = settle_cnt + SET_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (i_stop) stop_pend_n = 1'b1;
                // Trigger cycle plus HOLDOFF cycles pass before idle flags are trusted.
                if (hold_cnt == HOLD_W'(HOLDOFF)) begin
                    settle_cnt_n = '0;
                    state_n      = ST_SETTLE;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_n = ST_STOPPED;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_STOPPED;
            settle_cnt    <= '0;
            hold_cnt      <= '0;
            stop_pend     <= 1'b0;
            target        <= '0;
            o_cycle_count <= '0;
            o_trigger     <= 1'b0;
            o_active      <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state         <= state_n;
            settle_cnt    <= settle_cnt_n;
            hold_cnt      <= hold_cnt_n;
            stop_pend     <= stop_pend_n;
            target        <= target_n;
            o_cycle_count <= count_n;
            o_trigger     <= trigger_n;
            o_active      <= active_n;
            o_done        <= done_n;
        end
    end

endmodule

// File: tb/tb_nx_grid_sequencer.sv
// Bench for nx_grid_sequencer: per-edge stimulus tables compared against a
// window-scanning reference model, on a 32-bit and a 3-bit counter instance.
module tb_nx_grid_sequencer;

    localparam int unsigned NODES    = 16;
    localparam int          L        = 256;
    localparam int          SETTLE_C = 2;
    localparam int          HOLD_C   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [31:0]       cycles = '0;
    logic [NODES-1:0]  idle = '1;
    logic              trig, act, done, trig3, act3, done3;
    logic [31:0]       cnt;
    logic [2:0]        cnt3;

    nx_grid_sequencer #(.NODES(NODES), .COUNT_W(32), .SETTLE(SETTLE_C), .HOLDOFF(HOLD_C)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_cycles(cycles),
        .i_node_idle(idle), .o_trigger(trig), .o_active(act), .o_done(done), .o_cycle_count(cnt));

    nx_grid_sequencer #(.NODES(NODES), .COUNT_W(3), .SETTLE(SETTLE_C), .HOLDOFF(HOLD_C)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_cycles(cycles[2:0]),
        .i_node_idle(idle), .o_trigger(trig3), .o_active(act3), .o_done(done3), .o_cycle_count(cnt3));

    always #5 clk = ~clk;

    // Stimulus per clock edge, expected (e_ wide, s_ narrow) and observed (ob_ wide, o3_ narrow).
    logic             rs [L], st [L], sp [L];
    logic [31:0]      cy [L];
    logic [NODES-1:0] idv [L];
    logic             e_trig [L], e_act [L], e_done [L];
    logic [31:0]      e_cnt [L];
    logic             s_trig [L], s_act [L], s_done [L];
    logic [31:0]      s_cnt [L];
    logic             ob_trig [L], ob_act [L], ob_done [L];
    logic [31:0]      ob_cnt [L];
    logic             o3_trig [L], o3_act [L], o3_done [L];
    logic [31:0]      o3_cnt [L];

    int total = 0;
    int bad   = 0;

    task automatic clear_stim();
        for (int k = 0; k < L; k++) begin
            rs[k] = 1'b0; st[k] = 1'b0; sp[k] = 1'b0; cy[k] = '0; idv[k] = '1;
        end
    endtask

    // Reference: a trigger/done decision falls on edge k when the SETTLE samples
    // ending at k are all idle and none precede the earliest allowed sample.
    task automatic model(input int n, input logic [31:0] maxc);
        bit          run, pend, win;
        logic [31:0] c, tgt;
        int          from;
        run = 0; pend = 0; c = '0; tgt = '0; from = 0;
        for (int k = 0; k < n; k++) begin
            e_trig[k] = 1'b0;
            e_done[k] = 1'b0;
            if (rs[k]) begin
                run = 0; pend = 0; c = '0; tgt = '0;
            end else if (!run) begin
                if (st[k] && !sp[k]) begin
                    run = 1; pend = 0; c = '0; tgt = cy[k] & maxc; from = k + 1;
                end
            end else begin
                win = 1;
                for (int j = k - SETTLE_C + 1; j <= k; j++)
                    if (j < from || !(&idv[j])) win = 0;
                if (win) begin
                    if (pend || (tgt != 0 && c == tgt)) begin
                        e_done[k] = 1'b1;
                        run = 0;
                    end else begin
                        e_trig[k] = 1'b1;
                        if (c != maxc) c = c + 1;
                        from = k + HOLD_C + 2;
                    end
                end
                if (run && sp[k]) pend = 1;
            end
            e_act[k] = run;
            e_cnt[k] = c;
        end
    endtask

    task automatic run_tables(input int n);
        model(n, 32'd7);
        s_trig = e_trig; s_act = e_act; s_done = e_done; s_cnt = e_cnt;
        model(n, 32'hFFFF_FFFF);
        for (int k = 0; k < n; k++) begin
            rst = rs[k]; start = st[k]; stop = sp[k]; cycles = cy[k]; idle = idv[k];
            @(posedge clk);
            #1;
            ob_trig[k] = trig;  ob_act[k] = act;  ob_done[k] = done;  ob_cnt[k] = cnt;
            o3_trig[k] = trig3; o3_act[k] = act3; o3_done[k] = done3; o3_cnt[k] = 32'(cnt3);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset();
        int n = 4;
        clear_stim();
        rs[0] = 1'b1; rs[1] = 1'b1;
        run_tables(n);
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k]} !== {e_trig[k], e_act[k], e_done[k], e_cnt[k]}) begin
                bad++;
                $display("FAIL reset edge %0d: got t=%0b a=%0b d=%0b c=%0d want t=%0b a=%0b d=%0b c=%0d",
                         k, ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k], e_trig[k], e_act[k], e_done[k], e_cnt[k]);
            end
        end
        total++;
        if ({o3_trig[0], o3_act[0], o3_done[0], o3_cnt[0]} !== 35'd0) begin
            bad++;
            $display("FAIL reset_narrow: got t=%0b a=%0b d=%0b c=%0d want all 0", o3_trig[0], o3_act[0], o3_done[0], o3_cnt[0]);
        end
    endtask

    task automatic test_basic();
        int n = 18;
        clear_stim();
        rs[0] = 1'b1; st[1] = 1'b1; cy[1] = 32'd2;
        run_tables(n);
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k]} !== {e_trig[k], e_act[k], e_done[k], e_cnt[k]}) begin
                bad++;
                $display("FAIL basic edge %0d: got t=%0b a=%0b d=%0b c=%0d want t=%0b a=%0b d=%0b c=%0d",
                         k, ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k], e_trig[k], e_act[k], e_done[k], e_cnt[k]);
            end
        end
        // Start at edge 1: triggers SETTLE later and one period after that, done one period on.
        total++;
        if ({ob_act[1], ob_trig[3], ob_trig[8], ob_cnt[8], ob_done[13], ob_act[13]} !== {1'b1, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL basic_timing: got a1=%0b t3=%0b t8=%0b c8=%0d d13=%0b a13=%0b want 1 1 1 2 1 0",
                     ob_act[1], ob_trig[3], ob_trig[8], ob_cnt[8], ob_done[13], ob_act[13]);
        end
    endtask

    task automatic test_settle_restart();
        int n = 28;
        int ntrig = 0;
        clear_stim();
        rs[0] = 1'b1; st[1] = 1'b1; cy[1] = 32'd3;
        for (int k = 3; k <= 6; k++) idv[k] = 16'hFFF7;
        run_tables(n);
        for (int k = 0; k < n; k++) begin
            ntrig += int'(ob_trig[k]);
            total++;
            if ({ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k]} !== {e_trig[k], e_act[k], e_done[k], e_cnt[k]}) begin
                bad++;
                $display("FAIL settle_restart edge %0d: got t=%0b a=%0b d=%0b c=%0d want t=%0b a=%0b d=%0b c=%0d",
                         k, ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k], e_trig[k], e_act[k], e_done[k], e_cnt[k]);
            end
        end
        total++;
        if (ntrig !== 3 || ob_trig[8] !== 1'b1 || ob_done[23] !== 1'b1) begin
            bad++;
            $display("FAIL settle_restart_sum: got triggers=%0d t8=%0b d23=%0b want 3 1 1", ntrig, ob_trig[8], ob_done[23]);
        end
    endtask

    task automatic test_stop();
        int n = 28;
        clear_stim();
        rs[0] = 1'b1; st[1] = 1'b1; cy[1] = 32'd0; sp[20] = 1'b1;
        run_tables(n);
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k]} !== {e_trig[k], e_act[k], e_done[k], e_cnt[k]}) begin
                bad++;
                $display("FAIL stop edge %0d: got t=%0b a=%0b d=%0b c=%0d want t=%0b a=%0b d=%0b c=%0d",
                         k, ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k], e_trig[k], e_act[k], e_done[k], e_cnt[k]);
            end
        end
        total++;
        if (ob_done[23] !== 1'b1 || ob_cnt[27] !== 32'd4 || ob_trig[23] !== 1'b0) begin
            bad++;
            $display("FAIL stop_sum: got d23=%0b c27=%0d t23=%0b want 1 4 0", ob_done[23], ob_cnt[27], ob_trig[23]);
        end
    endtask

    task automatic test_start_stop();
        int n = 24;
        clear_stim();
        rs[0] = 1'b1; st[1] = 1'b1; sp[1] = 1'b1; cy[1] = 32'd1;
        st[12] = 1'b1; cy[12] = 32'd1;
        st[14] = 1'b1; cy[14] = 32'd5;
        run_tables(n);
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k]} !== {e_trig[k], e_act[k], e_done[k], e_cnt[k]}) begin
                bad++;
                $display("FAIL start_stop edge %0d: got t=%0b a=%0b d=%0b c=%0d want t=%0b a=%0b d=%0b c=%0d",
                         k, ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k], e_trig[k], e_act[k], e_done[k], e_cnt[k]);
            end
        end
        total++;
        if (ob_act[5] !== 1'b0 || ob_trig[3] !== 1'b0 || ob_done[19] !== 1'b1 || ob_cnt[20] !== 32'd1) begin
            bad++;
            $display("FAIL start_stop_sum: got a5=%0b t3=%0b d19=%0b c20=%0d want 0 0 1 1",
                     ob_act[5], ob_trig[3], ob_done[19], ob_cnt[20]);
        end
    endtask

    task automatic test_saturate();
        int n = 52;
        int ntrig = 0;
        clear_stim();
        rs[0] = 1'b1; st[1] = 1'b1; cy[1] = 32'd0; sp[45] = 1'b1;
        run_tables(n);
        for (int k = 0; k < n; k++) begin
            ntrig += int'(o3_trig[k]);
            total++;
            if ({o3_trig[k], o3_act[k], o3_done[k], o3_cnt[k]} !== {s_trig[k], s_act[k], s_done[k], s_cnt[k]}) begin
                bad++;
                $display("FAIL saturate edge %0d: got t=%0b a=%0b d=%0b c=%0d want t=%0b a=%0b d=%0b c=%0d",
                         k, o3_trig[k], o3_act[k], o3_done[k], o3_cnt[k], s_trig[k], s_act[k], s_done[k], s_cnt[k]);
            end
        end
        total++;
        if (ntrig !== 9 || o3_cnt[50] !== 32'd7 || ob_cnt[50] !== 32'd9 || o3_trig[43] !== 1'b1) begin
            bad++;
            $display("FAIL saturate_sum: got triggers=%0d c3=%0d c32=%0d t43=%0b want 9 7 9 1",
                     ntrig, o3_cnt[50], ob_cnt[50], o3_trig[43]);
        end
    endtask

    task automatic test_reset_mid();
        int n = 22;
        clear_stim();
        rs[0] = 1'b1; st[1] = 1'b1; cy[1] = 32'd2;
        rs[4] = 1'b1;
        st[6] = 1'b1; cy[6] = 32'd2;
        run_tables(n);
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k]} !== {e_trig[k], e_act[k], e_done[k], e_cnt[k]}) begin
                bad++;
                $display("FAIL reset_mid edge %0d: got t=%0b a=%0b d=%0b c=%0d want t=%0b a=%0b d=%0b c=%0d",
                         k, ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k], e_trig[k], e_act[k], e_done[k], e_cnt[k]);
            end
        end
        total++;
        if ({ob_trig[3], ob_act[4], ob_done[4], ob_cnt[4], ob_trig[8], ob_trig[13], ob_done[18]} !==
            {1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid_sum: got t3=%0b a4=%0b d4=%0b c4=%0d t8=%0b t13=%0b d18=%0b want 1 0 0 0 1 1 1",
                     ob_trig[3], ob_act[4], ob_done[4], ob_cnt[4], ob_trig[8], ob_trig[13], ob_done[18]);
        end
    endtask

    task automatic test_random();
        int n = 120;
        for (int it = 0; it < 6; it++) begin
            clear_stim();
            rs[0] = 1'b1;
            for (int k = 1; k < n; k++) begin
                if ($urandom % 5 == 0) idv[k][$urandom % NODES] = 1'b0;
                st[k] = ($urandom % 12 == 0);
                sp[k] = ($urandom % 20 == 0);
                cy[k] = $urandom % 5;
                rs[k] = ($urandom % 150 == 0);
            end
            run_tables(n);
            for (int k = 0; k < n; k++) begin
                total++;
                if ({ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k]} !== {e_trig[k], e_act[k], e_done[k], e_cnt[k]}) begin
                    bad++;
                    $display("FAIL random it%0d edge %0d: got t=%0b a=%0b d=%0b c=%0d want t=%0b a=%0b d=%0b c=%0d",
                             it, k, ob_trig[k], ob_act[k], ob_done[k], ob_cnt[k], e_trig[k], e_act[k], e_done[k], e_cnt[k]);
                end
                total++;
                if ({o3_trig[k], o3_act[k], o3_done[k], o3_cnt[k]} !== {s_trig[k], s_act[k], s_done[k], s_cnt[k]}) begin
                    bad++;
                    $display("FAIL random_narrow it%0d edge %0d: got t=%0b a=%0b d=%0b c=%0d want t=%0b a=%0b d=%0b c=%0d",
                             it, k, o3_trig[k], o3_act[k], o3_done[k], o3_cnt[k], s_trig[k], s_act[k], s_done[k], s_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_settle_restart();
        test_stop();
        test_start_stop();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
